pe_block_acc: RTL and testbench

Parametrised, pipelined successor to the 7x4 MAC row block. It computes ROWS signed dot products of length K per beat against one shared weight vector. It accumulates across multiple beats (chunks), so dot products longer than K need no external adders. A bias is added at the start of each group. Valid/ready handshakes sit on both sides. An optional ReLU is applied at the output. It sits between the patch/feature buffer and the output writeback in the linear-layer datapath.

---
 rtl/pe_pkg.sv | 20 ++
 rtl/pe_row_dot.sv | 32 +++
 rtl/pe_block_acc.sv | 128 ++++++++++++
 tb/tb_pe_block_acc.sv | 193 +++++++++++++++++++
 4 files changed

// File: rtl/pe_pkg.sv
// rtl/pe_pkg.sv - shared defaults, FSM state type and psum width helper for pe_block_acc
// Purpose: common definitions imported by pe_block_acc and pe_row_dot.
// Contents: DW_DEF/AW_DEF default widths, pe_state_e FSM states, psum_w().
package pe_pkg;

  localparam int DW_DEF = 8;
  localparam int AW_DEF = 32;

  typedef enum logic [1:0] {
    ST_ACCUM = 2'd0,
    ST_DRAIN = 2'd1,
    ST_HOLD  = 2'd2
  } pe_state_e;

  // Full-precision width of a K-term signed dot product of DW-bit operands.
  function automatic int psum_w(input int dw, input int k);
    return 2 * dw + $clog2(k);
  endfunction

endpackage

// File: rtl/pe_row_dot.sv
// rtl/pe_row_dot.sv - combinational K-term signed dot product for one row
// Purpose: dot_o = sum over k of signed(a_i[k]) * signed(w_i[k]), full precision.
// Ports:
//   a_i   in  K x DW  activations for this row
//   w_i   in  K x DW  shared weights
//   dot_o out PW      signed dot product
module pe_row_dot
  import pe_pkg::*;
#(
  parameter int K  = 4,
  parameter int DW = DW_DEF,
  parameter int PW = psum_w(DW_DEF, 4)
) (
  input  logic [K-1:0][DW-1:0] a_i,
  input  logic [K-1:0][DW-1:0] w_i,
  output logic signed [PW-1:0] dot_o
);

  // Assigning into a 2*DW-wide signed target widens both operands before
  // the multiply, so the product never truncates.
  logic signed [2*DW-1:0] prod;

  always_comb begin
    dot_o = '0;
    prod  = '0;
    for (int k = 0; k < K; k++) begin
      prod  = $signed(a_i[k]) * $signed(w_i[k]);
      dot_o = dot_o + PW'(prod);
    end
  end

endmodule

// File: rtl/pe_block_acc.sv
// rtl/pe_block_acc.sv - ROWS x K signed MAC block with multi-beat accumulation, bias and ReLU
// Purpose: two-stage pipeline; stage 1 registers per-row dot products,
//   stage 2 accumulates them across beats of a group and publishes the result.
// Ports:
//   clk, rst_n           clock, asynchronous active-low reset
//   in_valid/in_ready    input beat handshake
//   in_data[r][k], in_w  activations and shared weights
//   bias, relu_en        group bias and ReLU enable, used from the first beat
//   in_first/in_last     group delimiters
//   out_valid/out_ready  result handshake
//   out_data[r]          per-row result
module pe_block_acc
  import pe_pkg::*;
#(
  parameter int ROWS = 7,
  parameter int K    = 4,
  parameter int DW   = DW_DEF,
  parameter int AW   = AW_DEF
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [ROWS-1:0][K-1:0][DW-1:0] in_data,
  input  logic [K-1:0][DW-1:0]         in_w,
  input  logic [AW-1:0]                bias,
  input  logic                         in_first,
  input  logic                         in_last,
  input  logic                         relu_en,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [ROWS-1:0][AW-1:0]      out_data
);

  localparam int PW = psum_w(DW, K);

  pe_state_e state_q, state_d;
  logic      ready_q;
  logic      in_acc;

  logic                 s1_valid_q, s1_first_q, s1_last_q, s1_relu_q;
  logic signed [AW-1:0] s1_bias_q;
  logic signed [PW-1:0] dot       [ROWS];
  logic signed [PW-1:0] s1_psum_q [ROWS];

  logic signed [AW-1:0] acc_q [ROWS];
  logic signed [AW-1:0] acc_d [ROWS];
  logic                 open_q, relu_q;
  logic                 eff_first, relu_eff;

  // ready_q keeps in_ready low during reset and for nothing longer.
  assign in_ready  = ready_q && ((state_q == ST_ACCUM) ||
                                 ((state_q == ST_HOLD) && out_ready));
  assign in_acc    = in_valid && in_ready;

  for (genvar r = 0; r < ROWS; r++) begin : g_row
    pe_row_dot #(.K(K), .DW(DW), .PW(PW)) u_dot (
      .a_i   (in_data[r]),
      .w_i   (in_w),
      .dot_o (dot[r])
    );
  end

  // A beat with no group open starts one even without in_first.
  always_comb begin
    eff_first = s1_first_q || !open_q;
    relu_eff  = eff_first ? s1_relu_q : relu_q;
    for (int r = 0; r < ROWS; r++) begin
      acc_d[r] = (eff_first ? s1_bias_q : acc_q[r]) + AW'(s1_psum_q[r]);
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_ACCUM: if (in_acc && in_last) state_d = ST_DRAIN;
      ST_DRAIN: state_d = ST_HOLD;
      ST_HOLD:  if (out_ready) state_d = (in_acc && in_last) ? ST_DRAIN : ST_ACCUM;
      default:  state_d = ST_ACCUM;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_ACCUM;
      ready_q    <= 1'b0;
      s1_valid_q <= 1'b0;
      s1_first_q <= 1'b0;
      s1_last_q  <= 1'b0;
      s1_relu_q  <= 1'b0;
      s1_bias_q  <= '0;
      open_q     <= 1'b0;
      relu_q     <= 1'b0;
      out_valid  <= 1'b0;
      out_data   <= '0;
      for (int r = 0; r < ROWS; r++) begin
        s1_psum_q[r] <= '0;
        acc_q[r]     <= '0;
      end
    end else begin
      state_q    <= state_d;
      ready_q    <= 1'b1;
      s1_valid_q <= in_acc;
      if (in_acc) begin
        s1_first_q <= in_first;
        s1_last_q  <= in_last;
        s1_relu_q  <= relu_en;
        s1_bias_q  <= bias;
        for (int r = 0; r < ROWS; r++) s1_psum_q[r] <= dot[r];
      end

      if (out_valid && out_ready) out_valid <= 1'b0;

      if (s1_valid_q) begin
        relu_q <= relu_eff;
        open_q <= !s1_last_q;
        for (int r = 0; r < ROWS; r++) acc_q[r] <= acc_d[r];
        if (s1_last_q) begin
          out_valid <= 1'b1;
          for (int r = 0; r < ROWS; r++) begin
            out_data[r] <= (relu_eff && acc_d[r][AW-1]) ? '0 : acc_d[r];
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_pe_block_acc.sv
// tb/tb_pe_block_acc.sv - directed self-checking bench for pe_block_acc
module tb_pe_block_acc;

  logic                     clk = 1'b0;
  logic                     rst_n;
  logic                     in_valid;
  logic                     in_ready;
  logic [6:0][3:0][7:0]     in_data;
  logic [3:0][7:0]          in_w;
  logic [31:0]              bias;
  logic                     in_first;
  logic                     in_last;
  logic                     relu_en;
  logic                     out_valid;
  logic                     out_ready;
  logic [6:0][31:0]         out_data;

  int errors = 0;
  int checks = 0;

  pe_block_acc #(.ROWS(7), .K(4), .DW(8), .AW(32)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_w      (in_w),
    .bias      (bias),
    .in_first  (in_first),
    .in_last   (in_last),
    .relu_en   (relu_en),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_rows(input string tag, input logic [31:0] exp);
    for (int r = 0; r < 7; r++) chk(tag, out_data[r], exp);
  endtask

  task automatic beat(input logic [7:0] d, input logic [7:0] w0, input logic [7:0] w1,
                      input logic [7:0] w2, input logic [7:0] w3, input logic [31:0] b,
                      input logic f, input logic l, input logic rl);
    for (int r = 0; r < 7; r++)
      for (int k = 0; k < 4; k++) in_data[r][k] = d;
    in_w[0]  = w0;
    in_w[1]  = w1;
    in_w[2]  = w2;
    in_w[3]  = w3;
    bias     = b;
    in_first = f;
    in_last  = l;
    relu_en  = rl;
    in_valid = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; in_data = '0; in_w = '0; bias = '0;
    in_first = 1'b0; in_last = 1'b0; relu_en = 1'b0; out_ready = 1'b0;
    tick(); tick();
    chk("rst_in_ready", {31'd0, in_ready}, 32'd0);
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_out_data", out_data[0], 32'd0);
    rst_n = 1'b1;
    tick();
    chk("post_rst_in_ready", {31'd0, in_ready}, 32'd1);

    // 1: single beat, 1*(1+2+3+4) + 10 = 20
    beat(8'd1, 8'd1, 8'd2, 8'd3, 8'd4, 32'd10, 1'b1, 1'b1, 1'b0);
    tick();
    in_valid = 1'b0;
    chk("t1_valid_edge1", {31'd0, out_valid}, 32'd0);
    chk("t1_drain_ready", {31'd0, in_ready}, 32'd0);
    tick();
    chk("t1_valid_edge2", {31'd0, out_valid}, 32'd1);
    chk_rows("t1_data", 32'd20);
    chk("t1_hold_ready", {31'd0, in_ready}, 32'd0);
    out_ready = 1'b1;
    tick();
    chk("t1_valid_drop", {31'd0, out_valid}, 32'd0);
    chk("t1_ready_back", {31'd0, in_ready}, 32'd1);

    // 2: three beats of 2*1*4 = 8 each with a gap -> 24
    beat(8'd2, 8'd1, 8'd1, 8'd1, 8'd1, 32'd0, 1'b1, 1'b0, 1'b0);
    tick();
    beat(8'd2, 8'd1, 8'd1, 8'd1, 8'd1, 32'd999, 1'b0, 1'b0, 1'b0);
    tick();
    in_valid = 1'b0;
    tick(); tick(); tick();
    chk("t2_gap_no_valid", {31'd0, out_valid}, 32'd0);
    beat(8'd2, 8'd1, 8'd1, 8'd1, 8'd1, 32'd999, 1'b0, 1'b1, 1'b0);
    tick();
    in_valid = 1'b0;
    tick();
    chk("t2_valid", {31'd0, out_valid}, 32'd1);
    chk_rows("t2_data", 32'd24);
    tick();

    // 3: 4 * (-128 * 127) = -65024
    beat(8'h80, 8'h7F, 8'h7F, 8'h7F, 8'h7F, 32'd0, 1'b1, 1'b1, 1'b0);
    tick();
    in_valid = 1'b0;
    tick();
    chk("t3_valid", {31'd0, out_valid}, 32'd1);
    chk_rows("t3_neg", 32'hFFFF0200);
    tick();
    beat(8'h80, 8'h7F, 8'h7F, 8'h7F, 8'h7F, 32'd0, 1'b1, 1'b1, 1'b1);
    tick();
    in_valid = 1'b0;
    tick();
    chk_rows("t3_relu", 32'd0);
    tick();

    // 4: back-pressure, then overlapping handshakes (4 then 3*4+1 = 13)
    out_ready = 1'b0;
    beat(8'd1, 8'd1, 8'd1, 8'd1, 8'd1, 32'd0, 1'b1, 1'b1, 1'b1);
    tick();
    in_valid = 1'b0;
    tick();
    for (int i = 0; i < 5; i++) begin
      chk("t4_hold_valid", {31'd0, out_valid}, 32'd1);
      chk("t4_hold_data", out_data[3], 32'd4);
      chk("t4_hold_ready", {31'd0, in_ready}, 32'd0);
      tick();
    end
    beat(8'd3, 8'd1, 8'd1, 8'd1, 8'd1, 32'd1, 1'b1, 1'b1, 1'b0);
    out_ready = 1'b1;
    #1;
    chk("t4_comb_ready", {31'd0, in_ready}, 32'd1);
    tick();
    in_valid = 1'b0;
    chk("t4_valid_gap", {31'd0, out_valid}, 32'd0);
    tick();
    chk("t4_valid2", {31'd0, out_valid}, 32'd1);
    chk_rows("t4_data2", 32'd13);
    tick();

    // 5: reset mid-group; next beat without in_first uses bias: 5 + 20 = 25
    beat(8'd1, 8'd1, 8'd1, 8'd1, 8'd1, 32'd50, 1'b1, 1'b0, 1'b0);
    tick();
    tick();
    in_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("t5_rst_valid", {31'd0, out_valid}, 32'd0);
    chk("t5_rst_ready", {31'd0, in_ready}, 32'd0);
    chk("t5_rst_data", out_data[6], 32'd0);
    tick();
    rst_n = 1'b1;
    tick();
    chk("t5_ready", {31'd0, in_ready}, 32'd1);
    beat(8'd5, 8'd1, 8'd1, 8'd1, 8'd1, 32'd5, 1'b0, 1'b1, 1'b0);
    tick();
    in_valid = 1'b0;
    tick();
    chk("t5_valid", {31'd0, out_valid}, 32'd1);
    chk_rows("t5_data", 32'd25);
    tick();

    // 6: in_first mid-group restarts: 100 + 4 = 104
    beat(8'd1, 8'd1, 8'd1, 8'd1, 8'd1, 32'd7, 1'b1, 1'b0, 1'b0);
    tick();
    beat(8'd1, 8'd1, 8'd1, 8'd1, 8'd1, 32'd7, 1'b0, 1'b0, 1'b0);
    tick();
    beat(8'd1, 8'd1, 8'd1, 8'd1, 8'd1, 32'd100, 1'b1, 1'b1, 1'b0);
    tick();
    in_valid = 1'b0;
    tick();
    chk("t6_valid", {31'd0, out_valid}, 32'd1);
    chk_rows("t6_data", 32'd104);
    tick();
    chk("t6_valid_drop", {31'd0, out_valid}, 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
